// File: rtl/cic_comb_decimator.sv
// CIC decimator back end: keeps one of every R valid samples and runs it through
// M comb stages with differential delay D. Optional macro COMB_PIPE_EN registers every comb stage.
module cic_comb_decimator #(
  parameter int R    = 4,
  parameter int M    = 1,
  parameter int D    = 1,
  parameter int BITS = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [BITS-1:0] stream_in,
  input  logic            valid,
  output logic [BITS-1:0] stream_out,
  output logic            ready
);

  localparam int PW = (R > 1) ? $clog2(R) : 1;

  logic [PW-1:0]   phase;
  logic            strobe;
  logic [M-1:0]    stage_en;
  logic [BITS-1:0] comb_in  [M];
  logic [BITS-1:0] comb_out [M];
  logic [BITS-1:0] dly      [M][D];

  assign strobe = valid && (phase == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= '0;
    end else if (valid) begin
      phase <= (phase == PW'(R - 1)) ? '0 : phase + 1'b1;
    end
  end

  // Each stage's delay line only shifts when that stage's input sample is valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < M; k++) begin
        for (int d = 0; d < D; d++) begin
          dly[k][d] <= '0;
        end
      end
    end else begin
      for (int k = 0; k < M; k++) begin
        if (stage_en[k]) begin
          dly[k][0] <= comb_in[k];
          for (int d = 1; d < D; d++) begin
            dly[k][d] <= dly[k][d-1];
          end
        end
      end
    end
  end

`ifdef COMB_PIPE_EN

  logic [BITS-1:0] pipe_reg [M];
  logic [M-1:0]    pipe_vld;

  always_comb begin
    for (int k = 0; k < M; k++) begin
      comb_in[k]  = (k == 0) ? stream_in : pipe_reg[(k == 0) ? 0 : k - 1];
      stage_en[k] = (k == 0) ? strobe : pipe_vld[(k == 0) ? 0 : k - 1];
      comb_out[k] = comb_in[k] - dly[k][D-1];
    end
  end

  // Stage registers hold their last result, so stream_out holds between samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld <= '0;
      for (int k = 0; k < M; k++) begin
        pipe_reg[k] <= '0;
      end
    end else begin
      pipe_vld <= stage_en;
      for (int k = 0; k < M; k++) begin
        if (stage_en[k]) begin
          pipe_reg[k] <= comb_out[k];
        end
      end
    end
  end

  assign stream_out = pipe_reg[M-1];
  assign ready      = pipe_vld[M-1];

`else

  always_comb begin
    logic [BITS-1:0] x;
    x = stream_in;
    for (int k = 0; k < M; k++) begin
      stage_en[k] = strobe;
      comb_in[k]  = x;
      comb_out[k] = x - dly[k][D-1];
      x           = comb_out[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stream_out <= '0;
      ready      <= 1'b0;
    end else begin
      ready <= strobe;
      if (strobe) begin
        stream_out <= comb_out[M-1];
      end
    end
  end

`endif

endmodule
